// File: rtl/axi_reg_slice_if.sv
// One AXI4 port (AW, W, B, AR, R). master drives requests and response readies;
// slave is the mirror image.
interface axi_reg_slice_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_reg_slice.sv
// AXI4 register slice; each channel is either a wire or a 2-entry skid buffer.
// Latency 0 (wire) or 1 cycle (skid); skid accepts until both entries are full, no bubbles.

module axi_reg_slice_ch #(
    parameter int DAT_W = 8,
    parameter int MODE  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [DAT_W-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [DAT_W-1:0] out_dat
);
    if (MODE == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst_n};
        assign out_vld = in_vld;
        assign out_dat = in_dat;
        assign in_rdy  = out_rdy;
    end else begin : g_skid
        localparam logic [1:0] EMPTY = 2'd0;
        localparam logic [1:0] ONE   = 2'd1;
        localparam logic [1:0] TWO   = 2'd2;

        logic [1:0]       state;
        logic [DAT_W-1:0] m_dat;
        logic [DAT_W-1:0] s_dat;
        logic             rdy_q;
        logic             push;
        logic             pop;

        assign push = in_vld && rdy_q;
        assign pop  = (state != EMPTY) && out_rdy;

        // rdy_q mirrors "next state is not TWO" so in_rdy never depends on out_rdy
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= EMPTY;
                m_dat <= '0;
                s_dat <= '0;
                rdy_q <= 1'b0;
            end else begin
                rdy_q <= 1'b1;
                case (state)
                    EMPTY: begin
                        if (push) begin
                            m_dat <= in_dat;
                            state <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            m_dat <= in_dat;
                        end else if (push) begin
                            s_dat <= in_dat;
                            state <= TWO;
                            rdy_q <= 1'b0;
                        end else if (pop) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            m_dat <= s_dat;
                            state <= ONE;
                        end else begin
                            rdy_q <= 1'b0;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end

        assign in_rdy  = rdy_q;
        assign out_vld = (state != EMPTY);
        assign out_dat = m_dat;

        a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
            (out_vld && !out_rdy) |=> $stable(out_dat));
    end
endmodule

module axi_reg_slice #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 32,
    parameter int AXI_DATA_W = 32,
    parameter int AW_MODE    = 1,
    parameter int W_MODE     = 1,
    parameter int B_MODE     = 1,
    parameter int AR_MODE    = 1,
    parameter int R_MODE     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    axi_reg_slice_if.slave   s_axi,
    axi_reg_slice_if.master  m_axi
);
    localparam int AX_W = AXI_ID_W + AXI_ADDR_W + 25;
    localparam int W_W  = AXI_ID_W + AXI_DATA_W + AXI_DATA_W / 8 + 1;
    localparam int B_W  = AXI_ID_W + 2;
    localparam int R_W  = AXI_ID_W + AXI_DATA_W + 3;

    logic [AX_W-1:0] aw_in_dat, aw_out_dat, ar_in_dat, ar_out_dat;
    logic [W_W-1:0]  w_in_dat, w_out_dat;
    logic [B_W-1:0]  b_in_dat, b_out_dat;
    logic [R_W-1:0]  r_in_dat, r_out_dat;

    // AW, W, AR flow s_axi -> m_axi; B and R flow m_axi -> s_axi
    assign aw_in_dat = {s_axi.awid, s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst,
                        s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos};
    assign {m_axi.awid, m_axi.awaddr, m_axi.awlen, m_axi.awsize, m_axi.awburst,
            m_axi.awlock, m_axi.awcache, m_axi.awprot, m_axi.awqos} = aw_out_dat;

    assign w_in_dat = {s_axi.wid, s_axi.wdata, s_axi.wstrb, s_axi.wlast};
    assign {m_axi.wid, m_axi.wdata, m_axi.wstrb, m_axi.wlast} = w_out_dat;

    assign b_in_dat = {m_axi.bid, m_axi.bresp};
    assign {s_axi.bid, s_axi.bresp} = b_out_dat;

    assign ar_in_dat = {s_axi.arid, s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst,
                        s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};
    assign {m_axi.arid, m_axi.araddr, m_axi.arlen, m_axi.arsize, m_axi.arburst,
            m_axi.arlock, m_axi.arcache, m_axi.arprot, m_axi.arqos} = ar_out_dat;

    assign r_in_dat = {m_axi.rid, m_axi.rdata, m_axi.rresp, m_axi.rlast};
    assign {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast} = r_out_dat;

    axi_reg_slice_ch #(.DAT_W(AX_W), .MODE(AW_MODE)) u_aw (
        .clk(clk), .rst_n(rst_n),
        .in_vld(s_axi.awvalid), .in_rdy(s_axi.awready), .in_dat(aw_in_dat),
        .out_vld(m_axi.awvalid), .out_rdy(m_axi.awready), .out_dat(aw_out_dat)
    );

    axi_reg_slice_ch #(.DAT_W(W_W), .MODE(W_MODE)) u_w (
        .clk(clk), .rst_n(rst_n),
        .in_vld(s_axi.wvalid), .in_rdy(s_axi.wready), .in_dat(w_in_dat),
        .out_vld(m_axi.wvalid), .out_rdy(m_axi.wready), .out_dat(w_out_dat)
    );

    axi_reg_slice_ch #(.DAT_W(B_W), .MODE(B_MODE)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_vld(m_axi.bvalid), .in_rdy(m_axi.bready), .in_dat(b_in_dat),
        .out_vld(s_axi.bvalid), .out_rdy(s_axi.bready), .out_dat(b_out_dat)
    );

    axi_reg_slice_ch #(.DAT_W(AX_W), .MODE(AR_MODE)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .in_vld(s_axi.arvalid), .in_rdy(s_axi.arready), .in_dat(ar_in_dat),
        .out_vld(m_axi.arvalid), .out_rdy(m_axi.arready), .out_dat(ar_out_dat)
    );

    axi_reg_slice_ch #(.DAT_W(R_W), .MODE(R_MODE)) u_r (
        .clk(clk), .rst_n(rst_n),
        .in_vld(m_axi.rvalid), .in_rdy(m_axi.rready), .in_dat(r_in_dat),
        .out_vld(s_axi.rvalid), .out_rdy(s_axi.rready), .out_dat(r_out_dat)
    );
endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: an all-skid instance driven through per-channel
// source/sink arrays, plus an instance with a wire AR channel.
module tb_axi_reg_slice;
    localparam int AWP    = 58;
    localparam int WP     = 38;
    localparam int BP     = 3;
    localparam int RP     = 36;
    localparam int N_RAND = 10000;
    localparam int LIMIT  = 60000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_reg_slice_if s ();
    axi_reg_slice_if m ();
    axi_reg_slice_if s2 ();
    axi_reg_slice_if m2 ();

    axi_reg_slice dut (.clk(clk), .rst_n(rst_n), .s_axi(s), .m_axi(m));
    axi_reg_slice #(.AR_MODE(0)) dut_mix (.clk(clk), .rst_n(rst_n), .s_axi(s2), .m_axi(m2));

    // channel index: 0 AW, 1 W, 2 B, 3 AR, 4 R
    logic [4:0]  src_vld, dst_rdy, src_rdy, dst_vld;
    logic [63:0] src_dat [5];
    logic [63:0] dst_dat [5];
    logic [63:0] mask [5];

    logic [31:0] mix_addr;
    logic        mix_arvalid, mix_awvalid, mix_arready;

    int checks = 0;
    int errors = 0;

    always_comb begin
        {s.awid, s.awaddr, s.awlen, s.awsize, s.awburst, s.awlock, s.awcache, s.awprot, s.awqos}
            = src_dat[0][AWP-1:0];
        s.awvalid = src_vld[0];
        m.awready = dst_rdy[0];
        {s.wid, s.wdata, s.wstrb, s.wlast} = src_dat[1][WP-1:0];
        s.wvalid = src_vld[1];
        m.wready = dst_rdy[1];
        {m.bid, m.bresp} = src_dat[2][BP-1:0];
        m.bvalid = src_vld[2];
        s.bready = dst_rdy[2];
        {s.arid, s.araddr, s.arlen, s.arsize, s.arburst, s.arlock, s.arcache, s.arprot, s.arqos}
            = src_dat[3][AWP-1:0];
        s.arvalid = src_vld[3];
        m.arready = dst_rdy[3];
        {m.rid, m.rdata, m.rresp, m.rlast} = src_dat[4][RP-1:0];
        m.rvalid = src_vld[4];
        s.rready = dst_rdy[4];
    end

    always_comb begin
        dst_dat[0] = 64'({m.awid, m.awaddr, m.awlen, m.awsize, m.awburst, m.awlock, m.awcache,
                          m.awprot, m.awqos});
        dst_dat[1] = 64'({m.wid, m.wdata, m.wstrb, m.wlast});
        dst_dat[2] = 64'({s.bid, s.bresp});
        dst_dat[3] = 64'({m.arid, m.araddr, m.arlen, m.arsize, m.arburst, m.arlock, m.arcache,
                          m.arprot, m.arqos});
        dst_dat[4] = 64'({s.rid, s.rdata, s.rresp, s.rlast});
        dst_vld = {s.rvalid, m.arvalid, s.bvalid, m.wvalid, m.awvalid};
        src_rdy = {m.rready, s.arready, m.bready, s.wready, s.awready};
    end

    always_comb begin
        {s2.awid, s2.awlen, s2.awsize, s2.awburst, s2.awlock, s2.awcache, s2.awprot, s2.awqos} = '0;
        s2.awaddr  = mix_addr;
        s2.awvalid = mix_awvalid;
        {s2.arid, s2.arlen, s2.arsize, s2.arburst, s2.arlock, s2.arcache, s2.arprot, s2.arqos} = '0;
        s2.araddr  = mix_addr;
        s2.arvalid = mix_arvalid;
        {s2.wid, s2.wdata, s2.wstrb, s2.wlast, s2.wvalid} = '0;
        s2.bready  = 1'b1;
        s2.rready  = 1'b1;
        m2.awready = 1'b1;
        m2.wready  = 1'b1;
        m2.arready = mix_arready;
        {m2.bid, m2.bresp, m2.bvalid} = '0;
        {m2.rid, m2.rdata, m2.rresp, m2.rlast, m2.rvalid} = '0;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] ra, rb, rc;
    logic [63:0] sb [5][4];
    logic [63:0] hold_d [5];
    int          wp [5], rp [5], sent [5], rcvd [5];
    logic [4:0]  sfire_prev, stall_prev;
    logic        done;
    int          cyc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 5; c++) src_dat[c] = '0;
        src_vld = '0;
        dst_rdy = '0;
        mix_addr = '0;
        mix_arvalid = 1'b0;
        mix_awvalid = 1'b0;
        mix_arready = 1'b1;
        mask[0] = (64'd1 << AWP) - 1;
        mask[1] = (64'd1 << WP) - 1;
        mask[2] = (64'd1 << BP) - 1;
        mask[3] = (64'd1 << AWP) - 1;
        mask[4] = (64'd1 << RP) - 1;

        // reset and release
        repeat (3) next_cycle();
        chk("rst_valids", dst_vld, 5'h00);
        chk("rst_readies", src_rdy, 5'h00);
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", src_rdy, 5'h00);
        next_cycle();
        chk("rdy_after_release", src_rdy, 5'h1f);
        chk("valids_after_release", dst_vld, 5'h00);
        chk("aw_payload_cleared", dst_dat[0], 64'h0);
        chk("r_payload_cleared", dst_dat[4], 64'h0);

        // W streaming, 16 beats at full rate
        dst_rdy = 5'b00010;
        for (int k = 0; k <= 17; k++) begin
            src_vld[1] = (k < 16);
            src_dat[1] = 64'({1'b0, 32'(k), 4'hf, (k == 15)});
            #1;
            chk("w_stream_vld", dst_vld[1], (k >= 1 && k <= 16));
            if (k >= 1 && k <= 16) begin
                chk("w_stream_data", m.wdata, 64'(k - 1));
                chk("w_stream_last", m.wlast, (k == 16));
            end
            if (k < 16) chk("w_stream_rdy", src_rdy[1], 1);
            next_cycle();
        end

        // R backpressure: A and B fill the slice, C waits
        ra = 64'({1'b0, 32'hA0A0_0001, 2'b00, 1'b0});
        rb = 64'({1'b1, 32'hB0B0_0002, 2'b10, 1'b0});
        rc = 64'({1'b0, 32'hC0C0_0003, 2'b01, 1'b1});
        dst_rdy = 5'b0;
        src_vld[4] = 1'b1;
        src_dat[4] = ra;
        #1;
        chk("r_rdy_empty", src_rdy[4], 1);
        next_cycle();
        src_dat[4] = rb;
        #1;
        chk("r_rdy_one", src_rdy[4], 1);
        chk("r_first_out", dst_dat[4], ra);
        next_cycle();
        src_dat[4] = rc;
        #1;
        chk("r_rdy_two", src_rdy[4], 0);
        chk("r_hold_a0", dst_dat[4], ra);
        next_cycle();
        chk("r_rdy_two_b", src_rdy[4], 0);
        chk("r_hold_a1", dst_dat[4], ra);
        chk("r_hold_vld", dst_vld[4], 1);
        dst_rdy[4] = 1'b1;
        next_cycle();
        chk("r_out_b", dst_dat[4], rb);
        chk("r_rdy_back", src_rdy[4], 1);
        next_cycle();
        src_vld[4] = 1'b0;
        chk("r_out_c", dst_dat[4], rc);
        chk("r_out_c_vld", dst_vld[4], 1);
        next_cycle();
        chk("r_drained", dst_vld[4], 0);

        // wire-mode AR next to skid-mode AW
        mix_addr = 32'h1000;
        mix_arvalid = 1'b1;
        #1;
        chk("ar_wire_vld", m2.arvalid, 1);
        chk("ar_wire_addr", m2.araddr, 64'h1000);
        mix_arready = 1'b0;
        #1;
        chk("ar_wire_rdy_lo", s2.arready, 0);
        mix_arready = 1'b1;
        mix_arvalid = 1'b0;
        mix_awvalid = 1'b1;
        #1;
        chk("ar_wire_vld_lo", m2.arvalid, 0);
        chk("aw_skid_pre", m2.awvalid, 0);
        next_cycle();
        mix_awvalid = 1'b0;
        #1;
        chk("aw_skid_vld", m2.awvalid, 1);
        chk("aw_skid_addr", m2.awaddr, 64'h1000);
        next_cycle();

        // random valid/ready on all five channels
        for (int c = 0; c < 5; c++) begin
            wp[c] = 0; rp[c] = 0; sent[c] = 0; rcvd[c] = 0;
            hold_d[c] = '0;
        end
        sfire_prev = '0;
        stall_prev = '0;
        done = 1'b0;
        cyc = 0;
        while (!done && cyc < LIMIT) begin
            for (int c = 0; c < 5; c++) begin
                if (!(src_vld[c] && !sfire_prev[c])) begin
                    src_vld[c] = (sent[c] < N_RAND) && ($urandom_range(1, 0) == 1);
                    src_dat[c] = {$urandom, $urandom} & mask[c];
                end
                dst_rdy[c] = ($urandom_range(1, 0) == 1);
            end
            #1;
            done = 1'b1;
            for (int c = 0; c < 5; c++) begin
                if (stall_prev[c]) begin
                    chk("stall_vld", dst_vld[c], 1);
                    chk("stall_dat", dst_dat[c], hold_d[c]);
                end
                if (dst_vld[c] && dst_rdy[c]) begin
                    chk("beat_expected", (wp[c] > rp[c]), 1);
                    if (wp[c] > rp[c]) chk("beat_order", dst_dat[c], sb[c][rp[c] % 4]);
                    rp[c]++;
                    rcvd[c]++;
                end
                sfire_prev[c] = src_vld[c] && src_rdy[c];
                if (sfire_prev[c]) begin
                    sb[c][wp[c] % 4] = src_dat[c];
                    wp[c]++;
                    sent[c]++;
                end
                stall_prev[c] = dst_vld[c] && !dst_rdy[c];
                hold_d[c] = dst_dat[c];
                if (rcvd[c] != N_RAND) done = 1'b0;
            end
            cyc++;
            next_cycle();
        end
        chk("random_complete", done, 1);
        src_vld = '0;
        dst_rdy = 5'h1f;
        next_cycle();

        // asynchronous reset with two beats held in B
        dst_rdy = '0;
        src_vld[2] = 1'b1;
        src_dat[2] = 64'h5;
        next_cycle();
        src_dat[2] = 64'h2;
        next_cycle();
        src_vld[2] = 1'b0;
        #1;
        chk("b_full_vld", dst_vld[2], 1);
        chk("b_full_rdy", src_rdy[2], 0);
        chk("b_head", dst_dat[2], 64'h5);
        rst_n = 1'b0;
        #1;
        chk("b_async_vld_clr", dst_vld[2], 0);
        chk("b_async_dat_clr", dst_dat[2], 64'h0);
        next_cycle();
        rst_n = 1'b1;
        dst_rdy = 5'h1f;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            chk("b_no_stale", dst_vld[2], 0);
        end
        chk("b_rdy_back", src_rdy[2], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
